// File: rtl/axis_mash11_dsm_pkg.sv
// Shared constants, the code type and helpers for the MASH 1-1 modulator.
package mash_pkg;

    // Legal range of the combined modulator code.
    localparam int MASH_Y_MIN = -1;
    localparam int MASH_Y_MAX = 2;

    // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form.
    // Polynomial exponents 16,14,13,11 map onto register bits 0,2,3,5.
    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'h002D;

    // Three bits are enough for -1..+2.
    typedef logic signed [2:0] mash_code_t;

    // One LFSR step: the XOR of the tapped bits enters at the top.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] state);
        return {^(state & LFSR_TAPS), state[LFSR_WIDTH-1:1]};
    endfunction

    // Noise-cancelling combine: y = c1 + c2 - c2_delayed.
    function automatic mash_code_t mash_combine(input logic c1, input logic c2, input logic c2_d);
        mash_code_t a;
        mash_code_t b;
        mash_code_t c;
        a = {2'b00, c1};
        b = {2'b00, c2};
        c = {2'b00, c2_d};
        return a + b - c;
    endfunction

endpackage

// File: rtl/axis_mash11_dsm_stage.sv
// First-order accumulator stage. acc/carry present the result of the add
// that will be committed on the next enabled edge, so a following stage can
// chain on the freshly updated residue within the same advance.
module mash_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic             cin,
    output logic [WIDTH-1:0] acc,
    output logic             carry
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH:0]   sum_next;

    // Modular add; the bit above the residue is the stage's carry-out.
    always_comb begin
        sum_next = {1'b0, acc_reg} + {1'b0, x} + {{WIDTH{1'b0}}, cin};
    end

    assign acc   = sum_next[WIDTH-1:0];
    assign carry = sum_next[WIDTH];

    // Residue register, updated only when the modulator advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= sum_next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/axis_mash11_dsm.sv
// Second-order MASH 1-1 delta-sigma modulator with AXI-Stream ports.
// Each accepted signed sample is turned into offset binary, pushed through two
// cascaded accumulators, and the carries are combined into a -1..+2 code held
// in a single output register. OUT_WIDTH must be at least 3.
module axis_mash11_dsm
    import mash_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          OUT_WIDTH = 5,
    parameter int          DITHER    = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    input  logic [WIDTH-1:0]     s_axis_data_tdata,
    input  logic                 s_axis_data_tvalid,
    output logic                 s_axis_data_tready,
    output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready
);

    logic                 advance;
    logic [WIDTH-1:0]     u_offset;
    logic                 dither_bit;
    logic                 c2_d_reg;
    logic                 m_tvalid_reg;
    logic [OUT_WIDTH-1:0] m_tdata_reg;
    mash_code_t           y_code;
    logic [OUT_WIDTH-1:0] y_ext;

    logic [WIDTH-1:0] stage_x     [2];
    logic [WIDTH-1:0] stage_acc   [2];
    logic             stage_cin   [2];
    logic             stage_carry [2];

    // Single output register without a skid buffer: accept whenever the
    // current beat is leaving or there is no beat at all.
    assign s_axis_data_tready = m_axis_data_tready | ~m_tvalid_reg;
    assign advance            = s_axis_data_tvalid & s_axis_data_tready;

    // Signed sample to offset binary: flipping the sign bit adds 2^(WIDTH-1).
    assign u_offset = {~s_axis_data_tdata[WIDTH-1], s_axis_data_tdata[WIDTH-2:0]};

    // Optional dither: LFSR bit used as the stage-1 carry-in.
    generate
        if (DITHER != 0) begin : g_dither
            logic [LFSR_WIDTH-1:0] lfsr_reg;

            // LFSR steps once per accepted sample.
            always_ff @(posedge aclk or negedge arst_n) begin
                if (!arst_n) begin
                    lfsr_reg <= LFSR_SEED;
                end else if (advance) begin
                    lfsr_reg <= lfsr_step(lfsr_reg);
                end
            end

            assign dither_bit = lfsr_reg[0];
        end else begin : g_no_dither
            assign dither_bit = 1'b0;
        end
    endgenerate

    // Stage 1 integrates the input, stage 2 integrates stage 1's new residue.
    assign stage_x[0]   = u_offset;
    assign stage_cin[0] = dither_bit;
    assign stage_x[1]   = stage_acc[0];
    assign stage_cin[1] = 1'b0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stage
            mash_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (aclk),
                .rst_n (arst_n),
                .en    (advance),
                .x     (stage_x[gi]),
                .cin   (stage_cin[gi]),
                .acc   (stage_acc[gi]),
                .carry (stage_carry[gi])
            );
        end
    endgenerate

    // The last stage's residue only feeds its own register.
    logic unused_last_residue;
    assign unused_last_residue = ^stage_acc[1];

    // Combine the carries and sign-extend to the output width.
    always_comb begin
        y_code = mash_combine(stage_carry[0], stage_carry[1], c2_d_reg);
        y_ext  = OUT_WIDTH'(y_code);
    end

    // Delayed stage-2 carry for the differentiator.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            c2_d_reg <= 1'b0;
        end else if (advance) begin
            c2_d_reg <= stage_carry[1];
        end
    end

    // Output register: load on accept, clear when drained with nothing new.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            m_tvalid_reg <= 1'b0;
            m_tdata_reg  <= '0;
        end else if (advance) begin
            m_tvalid_reg <= 1'b1;
            m_tdata_reg  <= y_ext;
        end else if (m_axis_data_tready) begin
            m_tvalid_reg <= 1'b0;
        end
    end

    assign m_axis_data_tdata  = m_tdata_reg;
    assign m_axis_data_tvalid = m_tvalid_reg;

endmodule

// File: tb/tb_axis_mash11_dsm.sv
// Scoreboard bench for axis_mash11_dsm (DITHER=0). The driver pushes the
// reference model's code for every accepted sample; the monitor pops and
// compares whenever an output beat is consumed.
module tb_axis_mash11_dsm;
    import mash_pkg::*;

    logic        aclk   = 1'b0;
    logic        arst_n = 1'b1;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [4:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    always #5 aclk = ~aclk;

    axis_mash11_dsm #(
        .WIDTH     (16),
        .OUT_WIDTH (5),
        .DITHER    (0),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int exp_q[$];
    int obs_y[$];
    int x_log[$];
    int obs_sum;

    // Reference model state: integrator contents as plain integers.
    int m_acc1;
    int m_acc2;
    int m_c2_prev;

    logic [31:0] phase;

    bit hold_valid;
    int hold_data;
    int mon_y;
    int exp_y;

    task automatic check_eq(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected within [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    function automatic void model_reset();
        m_acc1    = 0;
        m_acc2    = 0;
        m_c2_prev = 0;
    endfunction

    // One modulator step in integer arithmetic: overflow of each 2^16-modulus
    // integrator is its carry, y = c1 + c2 - previous c2.
    function automatic int model_step(input int x);
        int u, t1, t2, c1, c2, y;
        u      = x + 32768;
        t1     = m_acc1 + u;
        c1     = t1 / 65536;
        m_acc1 = t1 % 65536;
        t2     = m_acc2 + m_acc1;
        c2     = t2 / 65536;
        m_acc2 = t2 % 65536;
        y      = c1 + c2 - m_c2_prev;
        m_c2_prev = c2;
        return y;
    endfunction

    // Sample source: 0 fixed, 1 uniform random, 2 NCO sine (step 2^18 of 2^32).
    function automatic int next_x(input int kind, input int fixed_x);
        real a;
        if (kind == 0) return fixed_x;
        if (kind == 1) return int'($urandom_range(65535)) - 32768;
        a = 32767.0 * $sin(6.283185307179586 * real'(phase) / 4294967296.0);
        phase = phase + 32'h0004_0000;
        return $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
    endfunction

    // Monitor: consumes output beats, checks against the scoreboard and
    // checks that a stalled beat stays put.
    always @(negedge aclk) begin
        #2;
        if (!arst_n) begin
            hold_valid = 1'b0;
        end else if (m_tvalid) begin
            mon_y = $signed(m_tdata);
            if (hold_valid) check_eq("hold_tdata", mon_y, hold_data);
            if (m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got beat %0d, expected no beat", mon_y);
                end else begin
                    exp_y = exp_q.pop_front();
                    check_eq("y_model", mon_y, exp_y);
                    check_range("y_range", mon_y, MASH_Y_MIN, MASH_Y_MAX);
                    obs_sum += mon_y;
                    obs_y.push_back(mon_y);
                end
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_data  = mon_y;
                check_eq("stall_sready", s_tready, 0);
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    // Drive n accepted samples with random valid/ready duty.
    task automatic send(input int n, input int kind, input int fixed_x,
                        input int p_valid, input int p_ready);
        int sent  = 0;
        int guard = 0;
        int cur_x;
        cur_x = next_x(kind, fixed_x);
        while (sent < n && guard < 20 * n + 200) begin
            @(negedge aclk);
            guard++;
            s_tvalid = ($urandom_range(99) < p_valid);
            m_tready = ($urandom_range(99) < p_ready);
            s_tdata  = cur_x[15:0];
            #1;
            if (s_tvalid && s_tready) begin
                exp_q.push_back(model_step(cur_x));
                x_log.push_back(cur_x);
                sent++;
                cur_x = next_x(kind, fixed_x);
            end
        end
        if (sent < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got %0d beats accepted, expected %0d", sent, n);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        @(negedge aclk);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        while ((exp_q.size() != 0 || m_tvalid) && g < 100) begin
            @(negedge aclk);
            g++;
        end
        if (g >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d entries pending, expected 0", exp_q.size());
        end
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge aclk);
        #3;
        arst_n = 1'b0;
        #1;
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_tdata", $signed(m_tdata), 0);
        exp_q.delete();
        model_reset();
        s_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        arst_n = 1'b1;
        #1;
        check_eq("rst_sready", s_tready, 1);
        obs_sum = 0;
        obs_y.delete();
        x_log.delete();
    endtask

    initial begin
        int sy, su;
        real dev;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        s_tdata  = '0;
        obs_sum  = 0;
        phase    = '0;
        model_reset();
        #1 arst_n = 1'b0;
        #1;
        check_eq("init_tvalid", m_tvalid, 0);
        check_eq("init_tdata", $signed(m_tdata), 0);
        repeat (3) @(negedge aclk);
        arst_n = 1'b1;

        // Reset mid-stream while a beat is stalled at the output.
        send(5, 1, 0, 100, 100);
        m_tready = 1'b0;
        #1 check_eq("pre_rst_tvalid", m_tvalid, 1);
        do_reset();

        // u = 0: the modulator never carries.
        send(256, 0, -32768, 100, 100);
        drain();
        check_eq("sum_u0", obs_sum, 0);

        // u = 1/2 full scale.
        do_reset();
        send(1024, 0, 0, 90, 90);
        drain();
        check_range("sum_u_half", obs_sum, 511, 513);

        // u = 3/4 full scale.
        do_reset();
        send(4096, 0, 16384, 100, 100);
        drain();
        check_range("sum_u_3q", obs_sum, 3071, 3073);

        // Random samples with random handshakes.
        do_reset();
        send(1500, 1, 0, 70, 60);
        drain();

        // Backpressure: hold m_tready low for 10 cycles, then continue.
        send(20, 1, 0, 100, 100);
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        s_tdata  = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("bp_sready", s_tready, 0);
            check_eq("bp_tvalid", m_tvalid, 1);
            @(negedge aclk);
        end
        send(200, 1, 0, 100, 100);
        drain();

        // NCO sine: bit-exact against the model, then 64-beat window averages.
        do_reset();
        phase = '0;
        send(20000, 2, 0, 90, 90);
        drain();
        check_eq("sine_count", obs_y.size(), 20000);
        if (obs_y.size() == 20000 && x_log.size() == 20000) begin
            for (int w = 0; w < 20000 / 64; w++) begin
                sy = 0;
                su = 0;
                for (int k = 0; k < 64; k++) begin
                    sy += obs_y[w * 64 + k];
                    su += x_log[w * 64 + k] + 32768;
                end
                dev = real'(sy) / 64.0 - real'(su) / (64.0 * 65536.0);
                check_range("sine_avg_x1000", $rtoi(dev * 1000.0), -100, 100);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
